// File: rtl/power_window_trigger_if.sv
// Bundles the squared-sample input, control strobes and power/trigger outputs of
// power_window_trigger; master drives inputs, slave is the trigger block.
interface power_window_trigger_if #(
   parameter int unsigned DEMUX   = 16,
   parameter int unsigned SQRBITS = 6,
   parameter int unsigned PWRBITS = 12
);
   logic [DEMUX*SQRBITS-1:0] SQR;
   logic                     ENABLE;
   logic [PWRBITS-1:0]       THRESH;
   logic                     THRESH_WR;
   logic                     SCALER_CLR;
   logic [PWRBITS-1:0]       POWER;
   logic                     TRIG;
   logic                     ARMED;
   logic [15:0]              SCALER;

   modport master (
      output SQR, ENABLE, THRESH, THRESH_WR, SCALER_CLR,
      input  POWER, TRIG, ARMED, SCALER
   );

   modport slave (
      input  SQR, ENABLE, THRESH, THRESH_WR, SCALER_CLR,
      output POWER, TRIG, ARMED, SCALER
   );
endinterface

// File: rtl/power_window_trigger.sv
// Sliding-window power trigger with holdoff rate limiting.
// Define POWER_SCALER_EN to build the saturating 16-bit trigger scaler.
module power_window_trigger #(
   parameter int unsigned       DEMUX          = 16,
   parameter int unsigned       SQRBITS        = 6,
   parameter int unsigned       NWIN           = 4,
   parameter int unsigned       PWRBITS        = 12,
   parameter int unsigned       HOLDOFF        = 8,
   parameter logic [PWRBITS-1:0] THRESH_DEFAULT = 12'd2000
) (
   input logic                   clk,
   input logic                   rst,
   power_window_trigger_if.slave bus
);

   localparam int unsigned NPART = 4;
   localparam int unsigned PER   = DEMUX / NPART;
   localparam int unsigned PARTW = SQRBITS + 2;
   localparam int unsigned TOTW  = PARTW + 2;
   localparam int unsigned CNTW  = $clog2(NWIN + 1);
   localparam int unsigned HOLDW = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {StFill, StArmed, StHoldoff} state_e;

   logic [DEMUX*SQRBITS-1:0] sqr_q;
   logic                     in_vld_q, part_vld_q, tot_vld_q;
   logic [PARTW-1:0]         part_d [NPART];
   logic [PARTW-1:0]         part_q [NPART];
   logic [TOTW-1:0]          tot_d, tot_q;
   logic [TOTW-1:0]          win_q [NWIN];
   logic [PWRBITS-1:0]       power_d, power_q;
   logic [PWRBITS-1:0]       thresh_q;
   logic                     above;

   state_e           state_d, state_q;
   logic [CNTW-1:0]  fill_cnt_d, fill_cnt_q;
   logic [HOLDW-1:0] hold_cnt_d, hold_cnt_q;
   logic             trig_d, trig_q;

   always_comb begin
      for (int p = 0; p < int'(NPART); p++) begin
         part_d[p] = '0;
         for (int j = 0; j < int'(PER); j++) begin
            part_d[p] = part_d[p] + PARTW'(sqr_q[(p * PER + j) * SQRBITS +: SQRBITS]);
         end
      end
      tot_d = '0;
      for (int p = 0; p < int'(NPART); p++) begin
         tot_d = tot_d + TOTW'(part_q[p]);
      end
      // Window sum tracks the shift register contents exactly, so it never drifts.
      power_d = power_q + PWRBITS'(tot_q) - PWRBITS'(win_q[NWIN-1]);
   end

   assign above = (power_q > thresh_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sqr_q      <= '0;
         in_vld_q   <= 1'b0;
         part_vld_q <= 1'b0;
         tot_vld_q  <= 1'b0;
         for (int p = 0; p < int'(NPART); p++) part_q[p] <= '0;
         tot_q      <= '0;
         for (int i = 0; i < int'(NWIN); i++) win_q[i] <= '0;
         power_q    <= '0;
         thresh_q   <= THRESH_DEFAULT;
      end else begin
         sqr_q      <= bus.SQR;
         in_vld_q   <= 1'b1;
         part_vld_q <= in_vld_q;
         tot_vld_q  <= part_vld_q;
         for (int p = 0; p < int'(NPART); p++) part_q[p] <= part_d[p];
         tot_q      <= tot_d;
         win_q[0]   <= tot_q;
         for (int i = 1; i < int'(NWIN); i++) win_q[i] <= win_q[i-1];
         power_q    <= power_d;
         if (bus.THRESH_WR) thresh_q <= bus.THRESH;
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      hold_cnt_d = hold_cnt_q;
      trig_d     = 1'b0;
      unique case (state_q)
         StFill: begin
            // Arm on the edge that absorbs the last total needed to fill the window.
            if (tot_vld_q) begin
               if (fill_cnt_q == CNTW'(NWIN - 1)) state_d = StArmed;
               else fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
         StArmed: begin
            if (above && bus.ENABLE) begin
               trig_d     = 1'b1;
               hold_cnt_d = HOLDW'(HOLDOFF - 1);
               state_d    = StHoldoff;
            end
         end
         StHoldoff: begin
            if (hold_cnt_q == '0) state_d = StArmed;
            else hold_cnt_d = hold_cnt_q - 1'b1;
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFill;
         fill_cnt_q <= '0;
         hold_cnt_q <= '0;
         trig_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         trig_q     <= trig_d;
      end
   end

   assign bus.POWER = power_q;
   assign bus.TRIG  = trig_q;
   assign bus.ARMED = (state_q == StArmed);

`ifdef POWER_SCALER_EN
   logic [15:0] scaler_d, scaler_q;

   // A clear coincident with a trigger pulse still records that trigger.
   always_comb begin
      scaler_d = scaler_q;
      if (bus.SCALER_CLR) scaler_d = {15'd0, trig_q};
      else if (trig_q && (scaler_q != 16'hFFFF)) scaler_d = scaler_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) scaler_q <= '0;
      else     scaler_q <= scaler_d;
   end

   assign bus.SCALER = scaler_q;
`else
   logic unused_scaler_clr;
   assign unused_scaler_clr = bus.SCALER_CLR;
   assign bus.SCALER = '0;
`endif

endmodule

// File: doc/power_window_trigger.md
# power_window_trigger

Downstream consumer of the per-sample squared-sum stage: takes the 16 packed 6-bit squared values produced each clock, reduces them to a per-clock power total, maintains a sliding NWIN-clock power window, and issues a single-cycle trigger when the window exceeds a programmable threshold. A holdoff state machine rate-limits triggers. An optional scaler counts issued triggers.

## Interface
- DEMUX, 16, samples per clock (fixed by upstream packing)
- SQRBITS, 6, bits per squared sample (upstream max 63)
- NWIN, 4, window length in clocks (2..16)
- PWRBITS, 12, window-sum width (must hold 1008*NWIN)
- HOLDOFF, 8, clocks of holdoff after a trigger (≥1)
- THRESH_DEFAULT, 12'd2000, threshold loaded at reset

- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- SQR  input  DEMUX*SQRBITS  packed squares; sample i at [i*SQRBITS +: SQRBITS]; registered upstream
- ENABLE  input  1  trigger enable; low masks TRIG only
- THRESH  input  PWRBITS  new threshold value
- THRESH_WR  input  1  load strobe for THRESH
- SCALER_CLR  input  1  clears trigger scaler
- POWER  output  PWRBITS  current window sum (registered)
- TRIG  output  1  single-cycle trigger pulse
- ARMED  output  1  high in ARMED state
- SCALER  output  16  trigger count

## Operation
- Stage 1: four registered partial sums, each of 4 samples (max 252, 8 bits).
- Stage 2: registered per-clock total of the partials (max 1008, 10 bits), zero-extended to PWRBITS.
- Stage 3: NWIN-deep shift register of totals; running sum POWER <= POWER + newest - oldest (oldest = entry leaving the shift register). Unsigned, no overflow by PWRBITS rule.
- thresh_reg loads THRESH on the clock edge where THRESH_WR=1; new value applies to the comparison on the next cycle.
- Condition: POWER > thresh_reg (strict; equality does not trigger).
- State machine, evaluated each clock on current POWER:
  - FILL: after reset; counts totals absorbed into stage 3; go to ARMED once NWIN totals absorbed. TRIG never asserts.
  - ARMED: if condition && ENABLE: TRIG<=1 next edge, load holdoff counter with HOLDOFF-1, go to HOLDOFF. Condition with ENABLE=0: no TRIG, stay ARMED.
  - HOLDOFF: counter decrements; at 0 go to ARMED. Condition ignored.
- TRIG is high for exactly one clock per ARMED->HOLDOFF transition.
- Reset (any time, including mid-holdoff or mid-FILL): all pipeline registers, shift register, POWER, TRIG, ARMED, SCALER = 0; state = FILL; thresh_reg = THRESH_DEFAULT.

## Timing
- SQR sampled at edge k -> partials at k+1 -> total at k+2 -> included in POWER after k+3 -> TRIG asserted after edge k+4 (4 clocks SQR-to-TRIG).
- ARMED asserts NWIN+3 clocks after reset release (pipeline fill + window fill).
- Consecutive TRIGs under sustained condition: spacing HOLDOFF+1 clocks.
- THRESH_WR concurrent with a qualifying compare: comparison uses the old thresh_reg.
- SCALER_CLR and TRIG in the same cycle: SCALER = 1.

## Configuration
- POWER_SCALER_EN defined: SCALER is a 16-bit counter incremented on every TRIG, saturating at 16'hFFFF, cleared by SCALER_CLR (clear takes priority over saturation hold, but not over a coincident increment, per Timing).
- Not defined: no counter logic; SCALER driven constant 0; SCALER_CLR ignored. Port list identical both ways.

## Test plan
- Reset, SQR all zero for 50 clocks -> POWER=0, TRIG never high, ARMED high from clock NWIN+3.
- After ARMED, one clock of all samples=63, thresh 1000 -> POWER=1008 for exactly 4 clocks, one TRIG 4 clocks after the stimulus.
- Samples=63 sustained, THRESH_WR 3000 -> POWER settles at 4032; TRIG pulses every 9 clocks (HOLDOFF=8).
- Tune so POWER=2000 exactly with default threshold -> no TRIG; POWER=2001 -> TRIG.
- ENABLE=0 with POWER=4032 -> no TRIG, ARMED stays high; raise ENABLE -> TRIG next clock.
- Assert rst mid-HOLDOFF -> all outputs 0 immediately, state FILL, thresh back to 2000; with POWER_SCALER_EN, SCALER_CLR coincident with TRIG -> SCALER=1.
